// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised next-PC selection
// (trap > jump > stall > RAS pop > sequential) and a small circular
// return-address stack for call/return prediction.
module pc_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INSTR_BYTES  = 4,
  parameter int                    RAS_DEPTH    = 4,
  localparam int                   CW           = $clog2(RAS_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  trap_en,
  input  logic [ADDR_WIDTH-1:0] trap_addr,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  ras_push,
  input  logic                  ras_pop,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [CW-1:0]         ras_count,
  output logic                  ras_empty
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]         top_q, top_d;
  logic [CW-1:0]         count_q, count_d;

  // Stack entries; contents are don't-care after reset, so no reset.
  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic                  ras_we;
  logic [PW-1:0]         ras_waddr;
  logic [ADDR_WIDTH-1:0] ras_wdata;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  do_pop;

  assign pc_inc    = pc_q + ADDR_WIDTH'(INSTR_BYTES);
  assign ras_empty = (count_q == '0);
  assign do_pop    = ras_pop && !ras_empty;
  assign pc_out    = pc_q;
  assign ras_count = count_q;

  // Next-PC selection and RAS pointer/count bookkeeping.
  always_comb begin
    pc_d      = pc_q;
    top_d     = top_q;
    count_d   = count_q;
    ras_we    = 1'b0;
    ras_waddr = top_q;
    ras_wdata = pc_inc;
    if (trap_en) begin
      // Trap flushes the stack; any push/pop this cycle is dropped.
      pc_d    = trap_addr;
      count_d = '0;
      top_d   = '0;
    end else if (jump_en) begin
      pc_d = jump_addr;
    end else if (en) begin
      pc_d = do_pop ? ras_mem[top_q] : pc_inc;
      if (ras_push && do_pop) begin
        // Return immediately followed by a call: replace top in place.
        ras_we    = 1'b1;
        ras_waddr = top_q;
      end else if (ras_push) begin
        // Pointer wraps when full, overwriting the oldest entry.
        ras_we    = 1'b1;
        ras_waddr = top_q + PW'(1);
        top_d     = top_q + PW'(1);
        if (count_q != CW'(RAS_DEPTH)) begin
          count_d = count_q + CW'(1);
        end
      end else if (do_pop) begin
        top_d   = top_q - PW'(1);
        count_d = count_q - CW'(1);
      end
    end
  end

  // PC and stack pointer/count registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q    <= RESET_VECTOR;
      top_q   <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // One write-enabled register per stack entry.
  generate
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
      always_ff @(posedge clk) begin
        if (ras_we && (ras_waddr == PW'(gi))) begin
          ras_mem[gi] <= ras_wdata;
        end
      end
    end
  endgenerate

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised fetch-stage program counter, successor to the single-redirect PC. Selects the next PC from a prioritised set of sources: trap vector, resolved jump/branch, return-address-stack (RAS) prediction, sequential increment. Holds a small circular RAS for call/return prediction. Sits at the head of the 5-stage pipeline and drives the instruction memory address.

Parameters:
ADDR_WIDTH, 32, width of PC and all address ports
RESET_VECTOR, 32'h0000_0000, pc_out value on reset
INSTR_BYTES, 4, sequential increment and call return-address offset
RAS_DEPTH, 4, number of RAS entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
en  input  1  fetch enable; 0 = stall (hazard unit)
trap_en  input  1  trap/exception redirect request
trap_addr  input  ADDR_WIDTH  trap handler address
jump_en  input  1  resolved jump/taken-branch redirect from EX
jump_addr  input  ADDR_WIDTH  jump/branch target
ras_push  input  1  current fetch is a call; push pc_out+INSTR_BYTES
ras_pop  input  1  current fetch is a return; predict next PC from RAS top
pc_out  output  ADDR_WIDTH  current PC
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries
ras_empty  output  1  ras_count == 0 (combinational)

Behaviour:
- Reset (resetn=0, async, immediate): pc_out=RESET_VECTOR, ras_count=0, ras_empty=1, top pointer=0; entry contents don't-care. Reset mid-operation discards all pending requests.
- Next-PC priority, evaluated each rising edge:
  1. trap_en=1: pc_out<=trap_addr; RAS flushed (count=0); push/pop ignored. Applies even when en=0.
  2. else jump_en=1: pc_out<=jump_addr; RAS unchanged; push/pop ignored. Applies even when en=0.
  3. else en=0: pc_out and RAS hold.
  4. else ras_pop=1 and not empty: pc_out<=RAS top; count-1.
  5. else: pc_out<=pc_out+INSTR_BYTES.
- Push (en=1, no trap/jump): write pc_out+INSTR_BYTES at top+1; count+1, saturating at RAS_DEPTH. Push when full overwrites oldest entry (circular pointer wrap); count stays RAS_DEPTH.
- Simultaneous push and pop (not empty): pc_out<=old top; top entry replaced by pc_out+INSTR_BYTES; count unchanged.
- Pop when empty: ignored; sequential increment; push in same cycle still applies.
- Pops after overflow return the newest RAS_DEPTH entries only.
- Arithmetic modulo 2^ADDR_WIDTH; 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- Latency: every redirect visible on pc_out one cycle after the sampling edge; no combinational path from inputs to pc_out.

Test Plan:
(RESET_VECTOR=0x1000, RAS_DEPTH=4.)
- Reset then en=1 for 3 cycles -> pc_out 0x1000, 0x1004, 0x1008, 0x100C; ras_empty=1 throughout; resetn low mid-run -> pc_out=0x1000 immediately, without waiting for a clock edge.
- At pc 0x1008: ras_push 1 cycle, jump_en with jump_addr=0x2000 next cycle, run 2 cycles, ras_pop 1 cycle -> pc 0x200C pushed-free path, pop returns 0x100C, ras_count 1->0.
- en=0 with jump_en=1, jump_addr=0xCAFE_BABC -> pc_out=0xCAFE_BABC despite stall; en=0 alone next cycle -> pc holds.
- trap_en and jump_en both high, trap_addr=0x0080, jump_addr=0x3000, ras_count=2 -> pc_out=0x0080, ras_count=0.
- 5 pushes at pcs 0x1000..0x1010 then 5 pops -> pops yield 0x1014, 0x1010, 0x100C, 0x1008; 5th pop with empty RAS gives sequential increment; ras_count saturates at 4.
- Pop+push same cycle with top=0x1008 at pc 0x2000 -> pc_out=0x1008, top becomes 0x2004, count unchanged; pc 0xFFFF_FFFC increment -> 0x0000_0000.
